single_macc_sequencer: RTL and testbench

SINGLE_MACC_SEQUENCER -- requirements
Module: single_macc_sequencer

---
 rtl/single_macc_pkg.sv | 19 +
 rtl/single_macc_sequencer_if.sv | 35 +++
 rtl/single_macc_drain_delay.sv | 30 +++
 rtl/single_macc_sequencer.sv | 155 +++++++++++++++
 tb/tb_single_macc_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/single_macc_pkg.sv
// rtl/single_macc_pkg.sv - shared types, defaults and helpers for the single-MACC sequencer
package single_macc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seqState_t;

    localparam int DefTapsN       = 16;
    localparam int DefDecimationK = 2;
    localparam int DefMaccLatency = 3;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int addrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/single_macc_sequencer_if.sv
// rtl/single_macc_sequencer_if.sv - sample strobe, buffer addresses and MACC control bundle
interface single_macc_sequencer_if
    import single_macc_pkg::*;
#(
    parameter int TapsN = DefTapsN
);
    localparam int AddrW = addrWidth(TapsN);

    logic             DataNd_i;
    logic             DataWr_o;
    logic [AddrW-1:0] DataWrAddr_o;
    logic [AddrW-1:0] DataRdAddr_o;
    logic [AddrW-1:0] CoeffRdAddr_o;
    logic             MaccEn_o;
    logic             MaccFirst_o;
    logic             MaccLast_o;
    logic             DataValid_o;
    logic             Busy_o;
    logic             Overrun_o;

    // Sequencer side
    modport master (
        input  DataNd_i,
        output DataWr_o, DataWrAddr_o, DataRdAddr_o, CoeffRdAddr_o,
        output MaccEn_o, MaccFirst_o, MaccLast_o, DataValid_o, Busy_o, Overrun_o
    );

    // Sample source / datapath side
    modport slave (
        output DataNd_i,
        input  DataWr_o, DataWrAddr_o, DataRdAddr_o, CoeffRdAddr_o,
        input  MaccEn_o, MaccFirst_o, MaccLast_o, DataValid_o, Busy_o, Overrun_o
    );

endinterface

// File: rtl/single_macc_drain_delay.sv
// rtl/single_macc_drain_delay.sv - delays the last-tap marker through the MACC pipeline
module single_macc_drain_delay
    import single_macc_pkg::*;
#(
    parameter int MaccLatency = DefMaccLatency
) (
    input  logic Clk_i,
    input  logic Rst_i,
    input  logic Last_i,
    output logic Valid_o
);
    logic [MaccLatency:0] pipe;

    if (MaccLatency == 0) begin : gShort
        // Single stage: result valid the clock after the last tap
        always_ff @(posedge Clk_i or negedge Rst_i) begin
            if (!Rst_i) pipe <= '0;
            else        pipe <= Last_i;
        end
    end else begin : gLong
        // Shift the marker so each run yields its own pulse, even back-to-back
        always_ff @(posedge Clk_i or negedge Rst_i) begin
            if (!Rst_i) pipe <= '0;
            else        pipe <= {pipe[MaccLatency-1:0], Last_i};
        end
    end

    assign Valid_o = pipe[MaccLatency];

endmodule

// File: rtl/single_macc_sequencer.sv
// rtl/single_macc_sequencer.sv - decimating FIR tap sequencer driving one shared MACC
module single_macc_sequencer
    import single_macc_pkg::*;
#(
    parameter int DecimationK = DefDecimationK,
    parameter int TapsN       = DefTapsN,
    parameter int MaccLatency = DefMaccLatency
) (
    input  logic Clk_i,
    input  logic Rst_i,
    single_macc_sequencer_if.master bus
);
    localparam int AddrW  = addrWidth(TapsN);
    localparam int DrainW = addrWidth(MaccLatency);
    localparam logic [AddrW-1:0]  LastTap   = AddrW'(TapsN - 1);
    localparam logic [AddrW-1:0]  LastPhase = AddrW'(DecimationK - 1);
    localparam logic [DrainW-1:0] LastDrain = DrainW'(MaccLatency - 1);

    seqState_t         state, stateNext;
    logic [AddrW-1:0]  wrPtr, wrPtrNext;
    logic [AddrW-1:0]  phase, phaseNext;
    logic [AddrW-1:0]  tap, tapNext;
    logic [AddrW-1:0]  base, baseNext;
    logic [AddrW-1:0]  pendingBase, pendingBaseNext;
    logic              pending, pendingNext;
    logic              overrun, overrunNext;
    logic [DrainW-1:0] drainCnt, drainCntNext;

    logic              trigger;
    logic              maccEn, maccFirst, maccLast;
    logic [AddrW-1:0]  dataRdAddr, coeffRdAddr;

    assign trigger = bus.DataNd_i && (phase == LastPhase);

    // State register for the FSM and all pointers/counters
    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            state       <= IDLE;
            wrPtr       <= '0;
            phase       <= '0;
            tap         <= '0;
            base        <= '0;
            pendingBase <= '0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            drainCnt    <= '0;
        end else begin
            state       <= stateNext;
            wrPtr       <= wrPtrNext;
            phase       <= phaseNext;
            tap         <= tapNext;
            base        <= baseNext;
            pendingBase <= pendingBaseNext;
            pending     <= pendingNext;
            overrun     <= overrunNext;
            drainCnt    <= drainCntNext;
        end
    end

    // Next-state logic and per-tap MACC controls
    always_comb begin
        stateNext       = state;
        wrPtrNext       = wrPtr;
        phaseNext       = phase;
        tapNext         = tap;
        baseNext        = base;
        pendingBaseNext = pendingBase;
        pendingNext     = pending;
        overrunNext     = overrun;
        drainCntNext    = drainCnt;
        maccEn          = 1'b0;
        maccFirst       = 1'b0;
        maccLast        = 1'b0;
        dataRdAddr      = '0;
        coeffRdAddr     = '0;

        // Samples are always written, whatever the FSM is doing
        if (bus.DataNd_i) begin
            wrPtrNext = wrPtr + AddrW'(1);
            phaseNext = (phase == LastPhase) ? '0 : phase + AddrW'(1);
        end

        case (state)
            IDLE: begin
                if (trigger) begin
                    stateNext = RUN;
                    tapNext   = '0;
                    baseNext  = wrPtr;
                end
            end
            RUN: begin
                maccEn      = 1'b1;
                maccFirst   = (tap == '0);
                maccLast    = (tap == LastTap);
                coeffRdAddr = tap;
                dataRdAddr  = base - tap;
                tapNext     = tap + AddrW'(1);
                // One trigger can wait behind the current run; a second is lost
                if (trigger) begin
                    if (pending) begin
                        overrunNext = 1'b1;
                    end else begin
                        pendingNext     = 1'b1;
                        pendingBaseNext = wrPtr;
                    end
                end
                if (maccLast) begin
                    tapNext = '0;
                    if (pending) begin
                        baseNext    = pendingBase;
                        pendingNext = 1'b0;
                    end else if (trigger) begin
                        // Trigger on the last tap chains straight into the next run
                        baseNext    = wrPtr;
                        pendingNext = 1'b0;
                    end else begin
                        stateNext    = DRAIN;
                        drainCntNext = '0;
                    end
                end
            end
            DRAIN: begin
                drainCntNext = drainCnt + DrainW'(1);
                if (trigger) begin
                    stateNext = RUN;
                    tapNext   = '0;
                    baseNext  = wrPtr;
                end else if (drainCnt == LastDrain) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.DataWr_o      = bus.DataNd_i & Rst_i;
    assign bus.DataWrAddr_o  = wrPtr;
    assign bus.DataRdAddr_o  = dataRdAddr;
    assign bus.CoeffRdAddr_o = coeffRdAddr;
    assign bus.MaccEn_o      = maccEn;
    assign bus.MaccFirst_o   = maccFirst;
    assign bus.MaccLast_o    = maccLast;
    assign bus.Busy_o        = (state != IDLE);
    assign bus.Overrun_o     = overrun;

    single_macc_drain_delay #(
        .MaccLatency(MaccLatency)
    ) drainDelay (
        .Clk_i   (Clk_i),
        .Rst_i   (Rst_i),
        .Last_i  (maccLast),
        .Valid_o (bus.DataValid_o)
    );

endmodule

// File: tb/tb_single_macc_sequencer.sv
// tb/tb_single_macc_sequencer.sv - randomized self-checking bench against a run-schedule model
module tb_single_macc_sequencer;
    import single_macc_pkg::*;

    localparam int N = 16;
    localparam int L = 3;

    logic clk  = 1'b0;
    logic rstN = 1'b0;

    always #5 clk = ~clk;

    single_macc_sequencer_if #(.TapsN(N)) busK2 ();
    single_macc_sequencer_if #(.TapsN(N)) busK1 ();

    single_macc_sequencer #(.DecimationK(2), .TapsN(N), .MaccLatency(L)) dutK2 (
        .Clk_i (clk),
        .Rst_i (rstN),
        .bus   (busK2)
    );

    single_macc_sequencer #(.DecimationK(1), .TapsN(N), .MaccLatency(L)) dutK1 (
        .Clk_i (clk),
        .Rst_i (rstN),
        .bus   (busK1)
    );

    logic [31:0] outK2, outK1;
    assign outK2 = {13'd0, busK2.DataWr_o, busK2.DataWrAddr_o, busK2.DataRdAddr_o, busK2.CoeffRdAddr_o,
                    busK2.MaccEn_o, busK2.MaccFirst_o, busK2.MaccLast_o, busK2.DataValid_o,
                    busK2.Busy_o, busK2.Overrun_o};
    assign outK1 = {13'd0, busK1.DataWr_o, busK1.DataWrAddr_o, busK1.DataRdAddr_o, busK1.CoeffRdAddr_o,
                    busK1.MaccEn_o, busK1.MaccFirst_o, busK1.MaccLast_o, busK1.DataValid_o,
                    busK1.Busy_o, busK1.Overrun_o};

    typedef struct {
        int start;
        int base;
    } runT;

    runT runs[$];
    int  checks      = 0;
    int  errors      = 0;
    int  cyc         = 0;
    int  sampleCnt   = 0;
    int  curK        = 2;
    int  dutValids   = 0;
    int  modelValids = 0;
    bit  overrunM    = 1'b0;
    bit  useK1       = 1'b0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h want %h", tag, cyc, got, exp);
        end
    endtask

    // Expected outputs for the current cycle from the list of scheduled runs
    function automatic logic [31:0] modelOut(input bit nd);
        int tap;
        logic [3:0] wa, ra, ca;
        bit en, fi, la, va, bu;
        ra = '0; ca = '0; en = 0; fi = 0; la = 0; va = 0; bu = 0;
        foreach (runs[i]) begin
            tap = cyc - runs[i].start;
            if (tap >= 0 && tap < N) begin
                en = 1;
                ca = tap[3:0];
                ra = 4'((runs[i].base - tap + N) % N);
                fi = (tap == 0);
                la = (tap == N - 1);
            end
            if (cyc == runs[i].start + N + L) va = 1;
            if (cyc >= runs[i].start && cyc <= runs[i].start + N - 1 + L) bu = 1;
        end
        wa = 4'(sampleCnt % N);
        return {13'd0, nd, wa, ra, ca, en, fi, la, va, bu, overrunM};
    endfunction

    // Schedule a run for a trigger: right away if free, after the current run if one is active,
    // dropped with overrun if a run is already waiting
    task automatic modelAdvance(input bit nd);
        int endC;
        bit waiting, inRun;
        if (nd) begin
            if (sampleCnt % curK == curK - 1) begin
                waiting = 0; inRun = 0; endC = 0;
                foreach (runs[i]) begin
                    if (runs[i].start > cyc) waiting = 1;
                    if (cyc >= runs[i].start && cyc < runs[i].start + N - 1) begin
                        inRun = 1;
                        endC  = runs[i].start + N - 1;
                    end
                end
                if (waiting) overrunM = 1;
                else runs.push_back('{start: (inRun ? endC + 1 : cyc + 1), base: sampleCnt % N});
            end
            sampleCnt++;
        end
        while (runs.size() > 0 && runs[0].start + N + L < cyc) void'(runs.pop_front());
        cyc++;
    endtask

    task automatic cycle(input bit nd);
        logic [31:0] exp, got;
        @(posedge clk);
        #1;
        busK2.DataNd_i = useK1 ? 1'b0 : nd;
        busK1.DataNd_i = useK1 ? nd : 1'b0;
        @(negedge clk);
        got = useK1 ? outK1 : outK2;
        exp = modelOut(nd);
        checkVal("outs", got, exp);
        if (got[2]) dutValids++;
        if (exp[2]) modelValids++;
        modelAdvance(nd);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        busK2.DataNd_i = 1'b0;
        busK1.DataNd_i = 1'b0;
        rstN = 1'b0;
        #1;
        checkVal("rstNow", useK1 ? outK1 : outK2, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rstHold", useK1 ? outK1 : outK2, 32'd0);
        rstN = 1'b1;
        runs.delete();
        sampleCnt   = 0;
        overrunM    = 1'b0;
        dutValids   = 0;
        modelValids = 0;
    endtask

    initial begin
        busK2.DataNd_i = 1'b0;
        busK1.DataNd_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rstK2", outK2, 32'd0);
        checkVal("rstK1", outK1, 32'd0);
        rstN = 1'b1;

        // Sparse samples, one output per two samples
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1);
            repeat (15) cycle(1'b0);
        end
        repeat (10) cycle(1'b0);
        checkVal("validsSparse", dutValids, 32'd4);

        // Sample every cycle: pending, back-to-back runs, overrun
        doReset();
        repeat (40) cycle(1'b1);
        checkVal("overrunSet", {31'd0, busK2.Overrun_o}, 32'd1);
        repeat (60) cycle(1'b0);
        checkVal("overrunSticky", {31'd0, busK2.Overrun_o}, 32'd1);

        // Reset at tap 7 of a run
        doReset();
        repeat (2) cycle(1'b1);
        repeat (7) cycle(1'b0);
        doReset();
        repeat (20) cycle(1'b0);
        checkVal("noValidAfterRst", dutValids, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1);
            repeat (9) cycle(1'b0);
        end
        repeat (30) cycle(1'b0);

        // 1000 samples with gaps that never overrun
        doReset();
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1);
            repeat ($urandom_range(7, 11)) cycle(1'b0);
        end
        repeat (30) cycle(1'b0);
        checkVal("impulseValids", dutValids, 32'd500);
        checkVal("impulseModel", dutValids, modelValids);
        checkVal("impulseOverrun", {31'd0, busK2.Overrun_o}, 32'd0);

        // Random sample traffic, K=2
        doReset();
        repeat (1500) cycle($urandom_range(0, 3) == 0);

        // K=1: every sample triggers, pointer wraps
        useK1 = 1'b1;
        curK  = 1;
        doReset();
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1);
            repeat (19) cycle(1'b0);
        end
        repeat (5) cycle(1'b0);
        checkVal("validsK1", dutValids, 32'd20);

        // Trigger in the second drain cycle
        doReset();
        cycle(1'b1);
        repeat (17) cycle(1'b0);
        cycle(1'b1);
        repeat (30) cycle(1'b0);
        checkVal("validsDrainTrig", dutValids, 32'd2);

        // Random sample traffic, K=1
        doReset();
        repeat (1500) cycle($urandom_range(0, 7) == 0);
        checkVal("randomK1Valids", dutValids, modelValids);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
